unpack4simd: RTL and testbench

UNPACK4SIMD -- requirements
Module: unpack4simd

---
 rtl/simd_pkg.sv | 24 ++
 rtl/unpack4simd_lane_sel.sv | 33 +++
 rtl/unpack4simd.sv | 127 ++++++++++++
 tb/tb_unpack4simd.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simd_pkg
// Brief    : Shared lane geometry, index-width helper and unpacker state type
//            for the packed SIMD add/unpack blocks.
// Revision : 1.0 - initial release
// ============================================================================
package simd_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 12;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Width of a lane index; never zero so single-lane builds still have a port
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unpack4simd_lane_sel.sv
`default_nettype none
// ============================================================================
// Module   : unpack4simd_lane_sel
// Brief    : Lowest-set-bit finder: index, one-hot and single-bit flag.
// Revision : 1.0 - initial release
// ============================================================================
module unpack4simd_lane_sel
    import simd_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int IDX_W = idx_w(LANES)
) (
    input  logic [LANES-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic [LANES-1:0] onehot,
    output logic             only
);

    // Scan downward so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (mask[k]) begin
                idx = IDX_W'(k);
            end
        end
    end

    assign onehot = mask & (~mask + LANES'(1));
    assign only   = (mask != '0) && ((mask & (mask - LANES'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/unpack4simd.sv
`default_nettype none
// ============================================================================
// Module   : unpack4simd
// Brief    : Serialises the enabled lanes of a packed SIMD sum, one per cycle,
//            with optional unsigned saturation on lane carry.
// Revision : 1.0 - initial release
// ============================================================================
module unpack4simd
    import simd_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int SAT    = 0,
    localparam int IDX_W = idx_w(LANES)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [LANES-1:0]        in_carry,
    input  logic [LANES-1:0]        in_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANE_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_lane,
    output logic                    out_carry,
    output logic                    out_last
);

    state_t                  r_state;
    logic [LANES-1:0]        r_rem;
    logic [LANES-1:0]        r_cur_oh;
    logic [LANES-1:0]        r_carry;
    logic [LANES*LANE_W-1:0] r_data;

    logic                    w_in_xfer;
    logic                    w_out_xfer;
    logic [LANES-1:0]        w_nxt_rem;
    logic [LANES-1:0]        w_nxt_carry;
    logic [LANES*LANE_W-1:0] w_nxt_data;
    logic [IDX_W-1:0]        w_sel_idx;
    logic [LANES-1:0]        w_sel_oh;
    logic                    w_sel_only;
    logic [LANE_W-1:0]       w_lane_bits;
    logic                    w_lane_carry;
    logic [LANE_W-1:0]       w_lane_out;

    assign in_ready   = (r_state == IDLE) || (out_valid && out_ready && out_last);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // A new word can only be taken once the held one is finished, so it simply replaces it
    always_comb begin
        w_nxt_rem   = r_rem;
        w_nxt_data  = r_data;
        w_nxt_carry = r_carry;
        if (w_in_xfer) begin
            w_nxt_rem   = in_mask;
            w_nxt_data  = in_data;
            w_nxt_carry = in_carry;
        end else if (w_out_xfer) begin
            w_nxt_rem = r_rem & ~r_cur_oh;
        end
    end

    unpack4simd_lane_sel #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_lane_sel (
        .mask   (w_nxt_rem),
        .idx    (w_sel_idx),
        .onehot (w_sel_oh),
        .only   (w_sel_only)
    );

    // AND-OR lane mux keyed by the one-hot select
    always_comb begin
        w_lane_bits  = '0;
        w_lane_carry = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (w_sel_oh[k]) begin
                w_lane_bits  = w_lane_bits | w_nxt_data[k*LANE_W +: LANE_W];
                w_lane_carry = w_lane_carry | w_nxt_carry[k];
            end
        end
    end

    assign w_lane_out = ((SAT != 0) && w_lane_carry) ? {LANE_W{1'b1}} : w_lane_bits;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_cur_oh  <= '0;
            r_carry   <= '0;
            r_data    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_carry <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            r_rem    <= w_nxt_rem;
            r_data   <= w_nxt_data;
            r_carry  <= w_nxt_carry;
            r_cur_oh <= w_sel_oh;
            if (w_nxt_rem != '0) begin
                r_state   <= EMIT;
                out_valid <= 1'b1;
                out_data  <= w_lane_out;
                out_lane  <= w_sel_idx;
                out_carry <= w_lane_carry;
                out_last  <= w_sel_only;
            end else begin
                r_state   <= IDLE;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_lane  <= '0;
                out_carry <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unpack4simd.sv
`default_nettype none
// ============================================================================
// Module   : tb_unpack4simd
// Brief    : Scoreboard bench driving a wrapping and a saturating unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unpack4simd;

    typedef struct {
        logic [1:0]  lane;
        logic [11:0] data;
        logic        carry;
        logic        last;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        ap_rst;
    logic        in_valid;
    logic [47:0] in_data;
    logic [3:0]  in_carry;
    logic [3:0]  in_mask;
    logic        out_ready;

    logic        in_ready0, o0_valid, o0_carry, o0_last;
    logic [11:0] o0_data;
    logic [1:0]  o0_lane;
    logic        in_ready1, o1_valid, o1_carry, o1_last;
    logic [11:0] o1_data;
    logic [1:0]  o1_lane;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];

    unpack4simd #(.LANES(4), .LANE_W(12), .SAT(0)) u_wrap (
        .ap_clk (clk), .ap_rst (ap_rst),
        .in_valid (in_valid), .in_ready (in_ready0),
        .in_data (in_data), .in_carry (in_carry), .in_mask (in_mask),
        .out_valid (o0_valid), .out_ready (out_ready),
        .out_data (o0_data), .out_lane (o0_lane),
        .out_carry (o0_carry), .out_last (o0_last)
    );

    unpack4simd #(.LANES(4), .LANE_W(12), .SAT(1)) u_sat (
        .ap_clk (clk), .ap_rst (ap_rst),
        .in_valid (in_valid), .in_ready (in_ready1),
        .in_data (in_data), .in_carry (in_carry), .in_mask (in_mask),
        .out_valid (o1_valid), .out_ready (out_ready),
        .out_data (o1_data), .out_lane (o1_lane),
        .out_carry (o1_carry), .out_last (o1_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e, input logic [1:0] lane,
                           input logic [11:0] data, input logic carry, input logic last,
                           input logic xfer);
        check({tag, "_lane"}, 64'(lane), 64'(e.lane));
        check({tag, "_data"}, 64'(data), 64'(e.data));
        check({tag, "_carry"}, 64'(carry), 64'(e.carry));
        check({tag, "_last"}, 64'(last), 64'(e.last));
        if (xfer && e.cyc >= 0) check({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
    endtask

    // Monitors: stalled outputs must already match the head entry; transfers pop it
    always @(negedge clk) begin
        if (o0_valid === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL wrap_unexpected: got lane %0d data %h, expected no output", o0_lane, o0_data);
            end else begin
                cmp_out("wrap", q0[0], o0_lane, o0_data, o0_carry, o0_last, out_ready);
                if (out_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (o1_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL sat_unexpected: got lane %0d data %h, expected no output", o1_lane, o1_data);
            end else begin
                cmp_out("sat", q1[0], o1_lane, o1_data, o1_carry, o1_last, out_ready);
                if (out_ready) void'(q1.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [1:0] lane, input logic [11:0] dwrap, input logic [11:0] dsat,
                            input logic carry, input logic last, input int ecyc);
        q0.push_back('{lane, dwrap, carry, last, ecyc});
        q1.push_back('{lane, dsat, carry, last, ecyc});
    endtask

    // Returns the cycle number following the accepting edge (first lane cycle)
    task automatic send_word(input logic [47:0] d, input logic [3:0] c, input logic [3:0] m, output int acc);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_carry = c;
        in_mask  = m;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready0) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check("drain_wrap", 64'(q0.size()), 64'd0);
        check("drain_sat", 64'(q1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, acc2, rel;
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_carry  = '0;
        in_mask   = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(o0_valid), 64'd0);
        check("rst_data", 64'(o0_data), 64'd0);
        check("rst_lane", 64'(o0_lane), 64'd0);
        check("rst_carry", 64'(o0_carry), 64'd0);
        check("rst_last", 64'(o0_last), 64'd0);
        check("rst_ready", 64'(in_ready0), 64'd1);
        check("rst_sat_valid", 64'(o1_valid), 64'd0);
        @(posedge clk);
        #1;
        ap_rst = 1'b0;
        rel = cyc;

        // Full word, lanes in order, one per cycle
        send_word(48'h003_FFF_800_001, 4'b0100, 4'hF, acc);
        check("first_accept_cycle", 64'(acc), 64'(rel + 1));
        push_exp(2'd0, 12'h001, 12'h001, 1'b0, 1'b0, acc);
        push_exp(2'd1, 12'h800, 12'h800, 1'b0, 1'b0, acc + 1);
        push_exp(2'd2, 12'hFFF, 12'hFFF, 1'b1, 1'b0, acc + 2);
        push_exp(2'd3, 12'h003, 12'h003, 1'b0, 1'b1, acc + 3);
        drain();

        // Carry on a lane whose bits are not all-ones: only SAT differs
        send_word(48'h000_123_000_000, 4'b0110, 4'b0100, acc);
        push_exp(2'd2, 12'h123, 12'hFFF, 1'b1, 1'b1, acc);
        drain();

        // Sparse mask with a two-cycle stall on the final lane
        send_word(48'h003_FFF_800_001, 4'b0100, 4'b1010, acc);
        push_exp(2'd1, 12'h800, 12'h800, 1'b0, 1'b0, acc);
        push_exp(2'd3, 12'h003, 12'h003, 1'b0, 1'b1, acc + 3);
        @(posedge clk); #1; out_ready = 1'b0;
        @(posedge clk); #1; out_ready = 1'b0;
        @(posedge clk); #1; out_ready = 1'b1;
        drain();

        // Back-to-back words with in_valid held high
        send_word(48'h000_000_000_0AB, 4'b0000, 4'b0001, acc);
        push_exp(2'd0, 12'h0AB, 12'h0AB, 1'b0, 1'b1, acc);
        push_exp(2'd3, 12'hCDE, 12'hFFF, 1'b1, 1'b1, acc + 1);
        send_word(48'hCDE_000_000_000, 4'b1000, 4'b1000, acc2);
        check("b2b_accept_cycle", 64'(acc2), 64'(acc + 1));
        drain();

        // Empty mask is swallowed, following word accepted immediately
        send_word(48'h111_222_333_444, 4'b1111, 4'b0000, acc);
        send_word(48'h003_FFF_800_001, 4'b0100, 4'b0100, acc2);
        check("mask0_next_accept", 64'(acc2), 64'(acc + 1));
        push_exp(2'd2, 12'hFFF, 12'hFFF, 1'b1, 1'b1, acc2);
        drain();

        // Reset during the lane-1 transfer discards lanes 2 and 3
        send_word(48'h003_FFF_800_001, 4'b0100, 4'hF, acc);
        push_exp(2'd0, 12'h001, 12'h001, 1'b0, 1'b0, acc);
        push_exp(2'd1, 12'h800, 12'h800, 1'b0, 1'b0, acc + 1);
        @(posedge clk); #1; ap_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 64'(o0_valid), 64'd0);
        check("midrst_ready", 64'(in_ready0), 64'd1);
        check("midrst_sat_valid", 64'(o1_valid), 64'd0);
        @(posedge clk); #1; ap_rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_q_wrap", 64'(q0.size()), 64'd0);
        check("midrst_q_sat", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
